// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: opcodes, register-index width, memory-stage FSM states.
// Used by both the execution and memory-access stages.
package mips16_pkg;

    localparam int OPW = 6;
    localparam int RW  = 3;

    typedef logic [OPW-1:0] opcode_t;

    localparam opcode_t OP_ADD = 6'd0;
    localparam opcode_t OP_SUB = 6'd1;
    localparam opcode_t OP_MOV = 6'd2;
    localparam opcode_t OP_MUL = 6'd3;
    localparam opcode_t OP_AND = 6'd4;
    localparam opcode_t OP_OR  = 6'd5;
    localparam opcode_t OP_XOR = 6'd6;
    localparam opcode_t OP_NOT = 6'd7;
    localparam opcode_t OP_ADI = 6'd8;
    localparam opcode_t OP_SBI = 6'd9;
    localparam opcode_t OP_MVI = 6'd10;
    localparam opcode_t OP_ANI = 6'd11;
    localparam opcode_t OP_ORI = 6'd12;
    localparam opcode_t OP_XRI = 6'd13;
    localparam opcode_t OP_NTI = 6'd14;
    localparam opcode_t OP_RET = 6'd15;
    localparam opcode_t OP_HLT = 6'd16;
    localparam opcode_t OP_LD  = 6'd17;
    localparam opcode_t OP_ST  = 6'd18;
    localparam opcode_t OP_IN  = 6'd19;
    localparam opcode_t OP_OUT = 6'd20;
    localparam opcode_t OP_JMP = 6'd21;
    localparam opcode_t OP_LS  = 6'd22;
    localparam opcode_t OP_RS  = 6'd23;
    localparam opcode_t OP_RSA = 6'd24;
    localparam opcode_t OP_JV  = 6'd25;
    localparam opcode_t OP_JNV = 6'd26;
    localparam opcode_t OP_JZ  = 6'd27;
    localparam opcode_t OP_JNZ = 6'd28;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mab_state_t;

    function automatic logic is_wb_op(input opcode_t op);
        logic r;
        r = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_MOV, OP_MUL, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_ADI, OP_SBI, OP_MVI, OP_ANI, OP_ORI, OP_XRI,
            OP_NTI, OP_IN, OP_LS, OP_RS, OP_RSA: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/memory_access_block_timer.sv
// Access-wait counter: cleared on request entry, saturates at TIMEOUT-1.
// expired is asserted while the count sits on the last allowed wait cycle.
module access_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/memory_access_block.sv
// MIPS16 memory-access stage: passes ALU results to writeback and runs
// LD/ST transactions against a handshaked data memory with a timeout.
module memory_access_block
    import mips16_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   ans_ex,
    input  logic [15:0]   DM_data,
    input  logic [5:0]    op_ex,
    input  logic [RW-1:0] rd_ex,
    input  logic [1:0]    flag_ex,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [15:0]   mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          wb_en,
    output logic [RW-1:0] wb_addr,
    output logic [15:0]   wb_data,
    output logic [1:0]    flag_wb,
    output logic          stall,
    output logic          mem_err
);

    mab_state_t    state_q, state_d;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          wb_en_q, wb_en_d;
    logic [RW-1:0] wb_addr_q, wb_addr_d;
    logic [15:0]   wb_data_q, wb_data_d;
    logic [1:0]    flag_q, flag_d;
    logic          err_q, err_d;
    logic          tmr_clear;
    logic          tmr_en;
    logic          expired;

    access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (expired)
    );

    assign stall = !reset &&
                   (((state_q == ST_IDLE) && is_mem_op(op_ex)) ||
                    ((state_q == ST_REQ) && !mem_ack && !expired));

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;
        flag_d    = stall ? flag_q : flag_ex;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (is_mem_op(op_ex)) begin
                    state_d   = ST_REQ;
                    addr_d    = ans_ex;
                    wdata_d   = DM_data;
                    rd_d      = rd_ex;
                    we_d      = (op_ex == OP_ST);
                    tmr_clear = 1'b1;
                end else if (is_wb_op(op_ex)) begin
                    wb_en_d   = 1'b1;
                    wb_addr_d = rd_ex;
                    wb_data_d = ans_ex;
                end
            end
            ST_REQ: begin
                tmr_en = !mem_ack;
                // An ack on the expiry cycle still completes the access
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    if (!we_q) begin
                        wb_en_d   = 1'b1;
                        wb_addr_d = rd_q;
                        wb_data_d = mem_rdata;
                    end
                end else if (expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            flag_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            flag_q    <= flag_d;
            err_q     <= err_d;
        end
    end

    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_en     = wb_en_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign flag_wb   = flag_q;
    assign mem_err   = err_q;

endmodule
